sa_job_arbiter: RTL and testbench

//  Shares one 3x3 systolic array (SysArr3x3) between two requesters.

---
 rtl/sa_job_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_sa_job_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_job_arbiter.sv
// sa_job_arbiter: shares one 3x3 systolic array between two job ports.
// Optional watchdog on the array run is built when SA_WDOG_EN is defined.
module sa_job_arbiter #(
  parameter int DATA_W     = 72,
  parameter int SETTLE_CYC = 12,
  parameter int WDOG_CYC   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_err,
  output logic              sa_start,
  output logic [DATA_W-1:0] sa_a,
  output logic [DATA_W-1:0] sa_b,
  input  logic              sa_valid,
  input  logic [DATA_W-1:0] sa_c,
  output logic              busy
);

  localparam int CMAX =
    (SETTLE_CYC > WDOG_CYC) ? SETTLE_CYC : WDOG_CYC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_IDLE,
    S_RUN,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_last;
  logic              r_id;
  logic [DATA_W-1:0] r_sa_a;
  logic [DATA_W-1:0] r_sa_b;
  logic              r_sa_start;
  logic [DATA_W-1:0] r_rsp_c;
  logic              r_rsp_valid;

  logic              w_pick0;
  logic              w_pick1;
  logic              w_grant;
  logic              w_done;
  logic              w_rsp_hs;

`ifdef SA_WDOG_EN
  logic              r_rsp_err;
  logic              w_abort;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to !last_grant.
  always_comb begin
    w_pick0 = req0_valid & (~req1_valid | r_last);
    w_pick1 = req1_valid & (~req0_valid | ~r_last);
  end

  // Next-state and counter logic for the job sequencer.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_rsp_hs  = 1'b0;
`ifdef SA_WDOG_EN
    w_abort   = 1'b0;
`endif
    unique case (r_state)
      S_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYC - 1)) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (w_pick0 | w_pick1) begin
          w_grant   = 1'b1;
          w_next    = S_RUN;
          w_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (sa_valid) begin
          w_done    = 1'b1;
          w_next    = S_RESP;
          w_cnt_nxt = '0;
        end
`ifdef SA_WDOG_EN
        else if (r_cnt == CW'(WDOG_CYC - 1)) begin
          w_abort   = 1'b1;
          w_next    = S_RESP;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      S_RESP: begin
        if (r_rsp_valid & rsp_ready) begin
          w_rsp_hs  = 1'b1;
          w_next    = S_RELEASE;
          w_cnt_nxt = '0;
        end
      end
      S_RELEASE: begin
`ifdef SA_WDOG_EN
        if (!sa_valid || r_cnt == CW'(SETTLE_CYC - 1)) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`else
        if (!sa_valid) begin
          w_next = S_IDLE;
        end
`endif
      end
      default: begin
        w_next    = S_SETTLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // State and shared cycle counter; reset replays the settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant bookkeeping; operands stay frozen until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_sa_a <= '0;
      r_sa_b <= '0;
    end else if (w_grant) begin
      r_last <= w_pick1;
      r_id   <= w_pick1;
      r_sa_a <= w_pick1 ? req1_a : req0_a;
      r_sa_b <= w_pick1 ? req1_b : req0_b;
    end
  end

  // Array start: raised on grant, dropped when the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa_start <= 1'b0;
    end else if (w_grant) begin
      r_sa_start <= 1'b1;
`ifdef SA_WDOG_EN
    end else if (w_done | w_abort) begin
`else
    end else if (w_done) begin
`endif
      r_sa_start <= 1'b0;
    end
  end

  // Response capture and hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_c     <= '0;
      r_rsp_valid <= 1'b0;
    end else if (w_done) begin
      r_rsp_c     <= sa_c;
      r_rsp_valid <= 1'b1;
`ifdef SA_WDOG_EN
    end else if (w_abort) begin
      r_rsp_c     <= '0;
      r_rsp_valid <= 1'b1;
`endif
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef SA_WDOG_EN
  // Error flag marks a response produced by the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_abort) begin
      r_rsp_err <= 1'b1;
    end else if (w_done | w_rsp_hs) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign req0_ready = w_grant & w_pick0;
  assign req1_ready = w_grant & w_pick1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_c      = r_rsp_c;
  assign sa_start   = r_sa_start;
  assign sa_a       = r_sa_a;
  assign sa_b       = r_sa_b;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sa_job_arbiter.sv
// tb_sa_job_arbiter: random + directed jobs against a transaction model.
// Array stand-in: valid 8 cycles after start, C = A ^ B.
module tb_sa_job_arbiter;

  localparam int SETTLE = 12;
  localparam int LAT    = 10;
  localparam int WDOG   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [71:0] req0_a = '0;
  logic [71:0] req0_b = '0;
  logic [71:0] req1_a = '0;
  logic [71:0] req1_b = '0;
  logic        rsp_ready = 1'b0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [71:0] rsp_c, sa_a, sa_b, sa_c;
  logic        sa_start, busy;
  logic        sa_valid = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sa_job_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .sa_start(sa_start), .sa_a(sa_a), .sa_b(sa_b),
    .sa_valid(sa_valid), .sa_c(sa_c), .busy(busy)
  );

  // Behavioural array: no reset, follows start only.
  bit arr_dead = 1'b0;
  int arr_cnt = 0;
  always @(posedge clk) begin
    if (!sa_start) begin
      arr_cnt  <= 0;
      sa_valid <= 1'b0;
    end else if (arr_cnt == 7) begin
      if (!arr_dead) sa_valid <= 1'b1;
    end else begin
      arr_cnt <= arr_cnt + 1;
    end
  end
  assign sa_c = sa_valid ? (sa_a ^ sa_b) : 72'h0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state (transaction level).
  bit          m_job, m_id, m_last;
  logic [71:0] m_a, m_b, m_sa_a, m_sa_b;
  int          m_t, m_wait, cyc;
  // Observations used by stimulus and literal pins.
  bit          acc0, acc1, prev_rv;
  int          dut_rsp_cnt = 0;
  int          first_ready_cyc, g_cyc, lat_obs;
  logic [71:0] last_c;
  logic        last_id;
  int          grant_log[$];

  initial begin
    bit idle, e0, e1, ev, hs, est;
    int rt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_sa_start", sa_start, 0);
        chk("rst_sa_a", sa_a, 0);
        chk("rst_sa_b", sa_b, 0);
        chk("rst_busy", busy, 1);
        m_job = 0; m_wait = SETTLE; m_last = 1;
        m_sa_a = '0; m_sa_b = '0; cyc = 0;
        acc0 = 0; acc1 = 0; prev_rv = 0;
        first_ready_cyc = -1;
      end else begin
        idle = !m_job && m_wait == 0;
        e0 = idle && req0_valid && (!req1_valid || m_last);
        e1 = idle && req1_valid && (!req0_valid || !m_last);
        rt = arr_dead ? WDOG + 1 : LAT;
        ev = m_job && m_t >= rt;
        est = m_job && m_t >= 1 && m_t < rt;
        chk("ready0", req0_ready, e0);
        chk("ready1", req1_ready, e1);
        chk("busy", busy, !idle);
        chk("rsp_valid", rsp_valid, ev);
        chk("sa_start", sa_start, est);
        chk("sa_a", sa_a, m_sa_a);
        chk("sa_b", sa_b, m_sa_b);
        if (ev) begin
          chk("rsp_id", rsp_id, m_id);
          chk("rsp_c", rsp_c, arr_dead ? 72'h0 : (m_a ^ m_b));
          chk("rsp_err", rsp_err, arr_dead);
        end
        acc0 = req0_ready;
        acc1 = req1_ready;
        if (req0_ready || req1_ready) begin
          grant_log.push_back(req1_ready ? 1 : 0);
          g_cyc = cyc;
          if (first_ready_cyc < 0) first_ready_cyc = cyc;
        end
        if (rsp_valid && !prev_rv) lat_obs = cyc - g_cyc;
        if (rsp_valid && rsp_ready) begin
          dut_rsp_cnt++;
          last_c = rsp_c;
          last_id = rsp_id;
        end
        prev_rv = rsp_valid;
        hs = ev && rsp_ready;
        if (m_wait > 0) m_wait--;
        if (m_job) m_t++;
        if (hs) begin
          m_job = 0;
          m_wait = 1;
        end
        if (e0 || e1) begin
          m_job = 1; m_t = 1; m_id = e1; m_last = e1;
          m_a = e1 ? req1_a : req0_a;
          m_b = e1 ? req1_b : req0_b;
          m_sa_a = m_a; m_sa_b = m_b;
        end
        cyc++;
      end
    end
  end

  // Stimulus knobs.
  int p0 = 0, p1 = 0, prr = 100;
  bit fix_data = 1'b0;

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0 || !req0_valid) req0_valid = ($urandom_range(99) < p0);
    if (acc1 || !req1_valid) req1_valid = ($urandom_range(99) < p1);
    if (!fix_data) begin
      req0_a = rnd72(); req0_b = rnd72();
      req1_a = rnd72(); req1_b = rnd72();
    end
    rsp_ready = ($urandom_range(99) < prr);
  endtask

  task automatic one_job(input bit r);
    if (r) begin req1_valid = 1'b1; acc1 = 1'b0; end
    else begin req0_valid = 1'b1; acc0 = 1'b0; end
  endtask

  task automatic wait_rsp(input int target, input int budget,
                          input string nm);
    int k;
    k = 0;
    while (dut_rsp_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, dut_rsp_cnt, target);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base, k;
    int exp_g[4] = '{0, 1, 0, 1};
    // 1: reset, single req0 job with fixed operands
    fix_data = 1'b1;
    do_reset(3);
    req0_a = 72'h010203040506070809;
    req0_b = 72'hFFFFFFFFFFFFFFFFFF;
    one_job(0);
    rsp_ready = 1'b1;
    wait_rsp(1, 60, "t1_done");
    chk("t1_first_ready", first_ready_cyc, SETTLE);
    chk("t1_latency", lat_obs, LAT);
    chk("t1_rsp_c", last_c, 72'hFEFDFCFBFAF9F8F7F6);
    chk("t1_rsp_id", last_id, 0);
    fix_data = 1'b0;
    repeat (5) tick();

    // 2: both requesters held valid, fresh arbitration
    rst_n = 1'b0;
    repeat (2) tick();
    grant_log.delete();
    p0 = 100; p1 = 100;
    base = dut_rsp_cnt;
    rst_n = 1'b1;
    one_job(0);
    one_job(1);
    wait_rsp(base + 4, 200, "t2_done");
    p0 = 0; p1 = 0;
    chk("t2_ngrants", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        chk($sformatf("t2_grant%0d", i), grant_log[i], exp_g[i]);
    end
    repeat (80) tick();

    // 3: consumer stalls for 20 cycles
    prr = 0;
    rsp_ready = 1'b0;
    one_job(1);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    chk("t3_rsp_seen", rsp_valid, 1);
    one_job(0);
    repeat (20) tick();
    prr = 100;
    repeat (60) tick();

    // 4: reset three cycles into RUN
    one_job(0);
    k = 0;
    while (!acc0 && k < 40) begin tick(); k++; end
    chk("t4_granted", acc0, 1);
    repeat (3) tick();
    do_reset(3);
    base = dut_rsp_cnt;
    one_job(0);
    wait_rsp(base + 1, 60, "t4_after_reset");
    repeat (5) tick();

`ifdef SA_WDOG_EN
    // 5: array never answers
    arr_dead = 1'b1;
    base = dut_rsp_cnt;
    one_job(1);
    wait_rsp(base + 1, 80, "t5_wdog_rsp");
    chk("t5_err", last_id, 1);
    repeat (3) tick();
    arr_dead = 1'b0;
    repeat (20) tick();
`endif

    // Random traffic; operands toggle every cycle on both ports
    p0 = 50; p1 = 50; prr = 60;
    repeat (900) tick();
    p0 = 0; p1 = 0; prr = 100;
    repeat (80) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
